// File: rtl/key_pkg.sv
// key_pkg
// Shared constants for the push-button conditioning path: the 2-bit FSM
// state encoding, the production debounce / long-press thresholds and the
// shortened thresholds used by simulation benches.
package key_pkg;

  // FSM state encoding (kept as plain constants for legacy tools)
  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_PRESS_DB   = 2'd1;
  localparam logic [1:0] ST_HELD       = 2'd2;
  localparam logic [1:0] ST_RELEASE_DB = 2'd3;

  // Production thresholds: 10 ms debounce, 1 s long press at 100 MHz
  localparam logic [19:0] DB_CNT_MAX_DEF   = 20'd1_000_000;
  localparam logic [28:0] LONG_CNT_MAX_DEF = 29'd100_000_000;

  // Short thresholds so benches finish in a few hundred cycles
  localparam logic [19:0] DB_CNT_MAX_SIM   = 20'd4;
  localparam logic [28:0] LONG_CNT_MAX_SIM = 29'd10;

  // The key counts as debounced-pressed (long_cnt running) in these states
  function automatic logic in_hold_window(input logic [1:0] state);
    return (state == ST_HELD) || (state == ST_RELEASE_DB);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
// Two-flop synchroniser for an asynchronous board input.
// Ports:
//   clk  - destination clock
//   rst  - asynchronous active-high reset, loads RST_VAL into both flops
//   d    - asynchronous input
//   q    - synchronised output
// RST_VAL should be the input's idle level so that reset release never
// presents a spurious edge downstream.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/key_debounce.sv
// key_debounce
// Synchronises a raw key, filters contact bounce with a counter-qualified
// FSM and produces a clean level plus single-cycle press / release /
// long-press pulses. key_press feeds the countdown display controller.
// Ports:
//   clk         - system clock
//   rst         - asynchronous active-high reset
//   key_in      - raw asynchronous key pin
//   key_level   - debounced pressed state (1 = pressed)
//   key_press   - one-cycle pulse on accepted press
//   key_release - one-cycle pulse on accepted release
//   key_long    - one-cycle pulse, once per press, after LONG_CNT_MAX held cycles
module key_debounce
  import key_pkg::*;
#(
  parameter logic [19:0] DB_CNT_MAX   = DB_CNT_MAX_DEF,
  parameter logic [28:0] LONG_CNT_MAX = LONG_CNT_MAX_DEF,
  parameter logic        ACTIVE_LOW   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  localparam logic [19:0] DB_LAST   = DB_CNT_MAX - 20'd1;
  localparam logic [28:0] LONG_LAST = LONG_CNT_MAX - 29'd1;

  logic        key_sync;
  logic        pressed_s;
  logic [1:0]  state;
  logic [19:0] db_cnt;
  logic [28:0] long_cnt;
  logic        long_done;

  // Reset the synchroniser to the released pin level so leaving reset
  // never looks like a press.
  sync_2ff #(
    .RST_VAL (ACTIVE_LOW)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (key_in),
    .q   (key_sync)
  );

  assign pressed_s = key_sync ^ ACTIVE_LOW;

  // Debounce FSM. A transition is accepted only after DB_CNT_MAX
  // consecutive samples at the new level; any disagreeing sample
  // returns to the previous stable state without a pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      db_cnt      <= 20'd0;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      key_press   <= 1'b0;
      key_release <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pressed_s) begin
            state  <= ST_PRESS_DB;
            db_cnt <= 20'd0;
          end
        end
        ST_PRESS_DB: begin
          if (!pressed_s) begin
            state  <= ST_IDLE;
            db_cnt <= 20'd0;
          end else if (db_cnt == DB_LAST) begin
            state     <= ST_HELD;
            key_press <= 1'b1;
            key_level <= 1'b1;
          end else begin
            db_cnt <= db_cnt + 20'd1;
          end
        end
        ST_HELD: begin
          if (!pressed_s) begin
            state  <= ST_RELEASE_DB;
            db_cnt <= 20'd0;
          end
        end
        ST_RELEASE_DB: begin
          if (pressed_s) begin
            state <= ST_HELD;
          end else if (db_cnt == DB_LAST) begin
            state       <= ST_IDLE;
            key_release <= 1'b1;
            key_level   <= 1'b0;
          end else begin
            db_cnt <= db_cnt + 20'd1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          db_cnt <= 20'd0;
        end
      endcase
    end
  end

  // Long-press timer. It keeps running through RELEASE_DB so a bounce
  // back into HELD does not restart it, and it is also evaluated on the
  // cycle a release is accepted, so long and release can pulse together.
  // Clearing in PRESS_DB guarantees a zero count on HELD entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      long_cnt  <= 29'd0;
      long_done <= 1'b0;
      key_long  <= 1'b0;
    end else begin
      key_long <= 1'b0;
      if (in_hold_window(state)) begin
        if (long_cnt != LONG_LAST) begin
          long_cnt <= long_cnt + 29'd1;
        end else if (!long_done) begin
          key_long  <= 1'b1;
          long_done <= 1'b1;
        end
      end else begin
        long_cnt  <= 29'd0;
        long_done <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce
// Scoreboard bench: each stimulus step pushes the edge numbers at which
// pulses must appear; a negedge monitor pops and compares them. One DUT
// is active-high, a second one is active-low.
module tb_key_debounce;
  import key_pkg::*;

  localparam int DB        = int'(DB_CNT_MAX_SIM);
  localparam int LONG      = int'(LONG_CNT_MAX_SIM);
  localparam int PRESS_LAT = DB + 3;

  logic clk;
  logic rst;
  logic key_in;
  logic key_in_n;
  logic key_level, key_press, key_release, key_long;
  logic key_level_n, key_press_n, key_release_n, key_long_n;

  int errors = 0;
  int checks = 0;
  int edge_cnt = 0;

  // 0..2: press/release/long of dut, 3..5: same for dut_n
  int    exp_q [6][$];
  string names [6] = '{"press", "release", "long", "press_n", "release_n", "long_n"};

  key_debounce #(
    .DB_CNT_MAX   (DB_CNT_MAX_SIM),
    .LONG_CNT_MAX (LONG_CNT_MAX_SIM),
    .ACTIVE_LOW   (1'b0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_in      (key_in),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release),
    .key_long    (key_long)
  );

  key_debounce #(
    .DB_CNT_MAX   (DB_CNT_MAX_SIM),
    .LONG_CNT_MAX (LONG_CNT_MAX_SIM),
    .ACTIVE_LOW   (1'b1)
  ) dut_n (
    .clk         (clk),
    .rst         (rst),
    .key_in      (key_in_n),
    .key_level   (key_level_n),
    .key_press   (key_press_n),
    .key_release (key_release_n),
    .key_long    (key_long_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=%0d expected=%0d (edge %0d)", tag, observed, expected, edge_cnt);
    end
  endtask

  // Pulse monitor: every pulse must match the head of its queue, and an
  // expected edge that passes without a pulse is reported as missed.
  always @(negedge clk) begin
    logic [5:0] pulses;
    int exp_edge;
    pulses = {key_long_n, key_release_n, key_press_n, key_long, key_release, key_press};
    if (!rst) begin
      for (int i = 0; i < 6; i++) begin
        if (pulses[i]) begin
          if (exp_q[i].size() == 0) begin
            checkOutput({names[i], "_unexpected"}, edge_cnt, -1);
          end else begin
            exp_edge = exp_q[i].pop_front();
            checkOutput(names[i], edge_cnt, exp_edge);
          end
        end else if (exp_q[i].size() > 0 && exp_q[i][0] <= edge_cnt) begin
          exp_edge = exp_q[i].pop_front();
          checkOutput({names[i], "_missed"}, 0, exp_edge);
        end
      end
    end
  end

  // Press the active-high key from a stable low, hold it for 'hold'
  // cycles, release and let it settle. Long fires only if the release is
  // accepted no earlier than the long expiry edge.
  task automatic applyStimulus(input int hold);
    int t;
    t = edge_cnt;
    key_in = 1'b1;
    exp_q[0].push_back(t + PRESS_LAT);
    if (hold >= LONG) exp_q[2].push_back(t + PRESS_LAT + LONG);
    repeat (hold) @(negedge clk);
    key_in = 1'b0;
    exp_q[1].push_back(t + hold + PRESS_LAT);
    repeat (PRESS_LAT + 5) @(negedge clk);
  endtask

  initial begin
    int t;
    rst      = 1'b1;
    key_in   = 1'b0;
    key_in_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_level",   key_level,   0);
    checkOutput("rst_press",   key_press,   0);
    checkOutput("rst_release", key_release, 0);
    checkOutput("rst_long",    key_long,    0);
    checkOutput("rst_level_n", key_level_n, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("idle_level_n", key_level_n, 0);

    // Clean press held 20 cycles with level edge checks
    t = edge_cnt;
    key_in = 1'b1;
    exp_q[0].push_back(t + PRESS_LAT);
    exp_q[2].push_back(t + PRESS_LAT + LONG);
    repeat (PRESS_LAT - 1) @(negedge clk);
    checkOutput("level_before_press", key_level, 0);
    @(negedge clk);
    checkOutput("level_after_press", key_level, 1);
    repeat (20 - PRESS_LAT) @(negedge clk);
    key_in = 1'b0;
    exp_q[1].push_back(t + 20 + PRESS_LAT);
    repeat (PRESS_LAT - 1) @(negedge clk);
    checkOutput("level_before_release", key_level, 1);
    @(negedge clk);
    checkOutput("level_after_release", key_level, 0);
    repeat (5) @(negedge clk);

    // Short glitch: no pulses
    key_in = 1'b1;
    repeat (3) @(negedge clk);
    key_in = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("glitch_level", key_level, 0);

    // Press bounce 1,0,1,0 then stable high
    key_in = 1'b1; @(negedge clk);
    key_in = 1'b0; @(negedge clk);
    key_in = 1'b1; @(negedge clk);
    key_in = 1'b0; @(negedge clk);
    applyStimulus(15);

    // Release bounce while held, before long expiry: no release, long not restarted
    t = edge_cnt;
    key_in = 1'b1;
    exp_q[0].push_back(t + PRESS_LAT);
    exp_q[2].push_back(t + PRESS_LAT + LONG);
    repeat (9) @(negedge clk);
    key_in = 1'b0;
    repeat (3) @(negedge clk);
    key_in = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("bounce_level", key_level, 1);
    repeat (9) @(negedge clk);
    key_in = 1'b0;
    exp_q[1].push_back(edge_cnt + PRESS_LAT);
    repeat (PRESS_LAT + 5) @(negedge clk);

    // Long press, release accepted on the long expiry edge, short hold
    applyStimulus(40);
    applyStimulus(LONG);
    applyStimulus(8);

    // Reset in PRESS_DB, key still held: re-debounced after release
    key_in = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("rst_pdb_level", key_level, 0);
    checkOutput("rst_pdb_press", key_press, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    t = edge_cnt;
    exp_q[0].push_back(t + PRESS_LAT);
    exp_q[2].push_back(t + PRESS_LAT + LONG);
    repeat (20) @(negedge clk);
    key_in = 1'b0;
    exp_q[1].push_back(t + 20 + PRESS_LAT);
    repeat (PRESS_LAT + 5) @(negedge clk);

    // Reset while held: level drops immediately, no release pulse
    t = edge_cnt;
    key_in = 1'b1;
    exp_q[0].push_back(t + PRESS_LAT);
    repeat (PRESS_LAT + 3) @(negedge clk);
    checkOutput("held_level", key_level, 1);
    rst = 1'b1;
    #1;
    checkOutput("rst_held_level", key_level, 0);
    key_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // Active-low key: drive low, hold, release
    t = edge_cnt;
    key_in_n = 1'b0;
    exp_q[3].push_back(t + PRESS_LAT);
    exp_q[5].push_back(t + PRESS_LAT + LONG);
    repeat (PRESS_LAT) @(negedge clk);
    checkOutput("level_n_pressed", key_level_n, 1);
    repeat (20 - PRESS_LAT) @(negedge clk);
    key_in_n = 1'b1;
    exp_q[4].push_back(t + 20 + PRESS_LAT);
    repeat (PRESS_LAT + 5) @(negedge clk);
    checkOutput("level_n_released", key_level_n, 0);

    repeat (10) @(negedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      checkOutput({"left_", names[i]}, exp_q[i].size(), 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
